// File: rtl/porti_pkg.sv
// Shared definitions for the PORTI input-port peripheral.
// Register indices and the debounce counter width.
package porti_pkg;

    localparam logic [2:0] PORTI_DATA = 3'd0;
    localparam logic [2:0] PORTI_RISE = 3'd1;
    localparam logic [2:0] PORTI_FALL = 3'd2;
    localparam logic [2:0] PORTI_RAW  = 3'd3;
    localparam logic [2:0] PORTI_IE   = 3'd4;

    localparam int CNT_W = 3;

endpackage

// File: rtl/porti_debounce_bit.sv
// One PORTI bit: two-flop synchroniser, debounce counter, level and edge pulses.
// rise/fall pulse in the cycle the debounced level is about to flip.
module porti_debounce_bit
    import porti_pkg::*;
#(
    parameter int STABLE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pin,
    output logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic             sync1;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    assign differ = raw != level;
    assign accept = tick && differ &&
                    (cnt + CNT_W'(1) == CNT_W'(STABLE));
    assign rise   = accept && !level;
    assign fall   = accept && level;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            raw   <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pin;
            raw   <= sync1;
            if (tick) begin
                if (accept) begin
                    level <= ~level;
                    cnt   <= '0;
                end else if (differ) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/porti_ctrl.sv
// Memory-mapped debounced input port with sticky W1C edge flags.
// Define PORTI_IRQ_EN to add the IE register at addr 4 and a registered irq.
module porti_ctrl
    import porti_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIV    = 10,
    parameter int STABLE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] porti,
    output logic             irq
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [TW-1:0]    tcnt;
    logic             tick;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise_p;
    logic [WIDTH-1:0] fall_p;
    logic [WIDTH-1:0] rise_f;
    logic [WIDTH-1:0] fall_f;
    logic [WIDTH-1:0] clr_rise;
    logic [WIDTH-1:0] clr_fall;
    logic [WIDTH-1:0] rd_val;
    logic             wr;

    assign tick = tcnt == TW'(DIV - 1);
    assign wr   = cs && wen;

    always_ff @(posedge clk) begin
        if (reset || tick) tcnt <= '0;
        else               tcnt <= tcnt + TW'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        porti_debounce_bit #(.STABLE(STABLE)) u_bit (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .pin   (porti[i]),
            .raw   (raw[i]),
            .level (level[i]),
            .rise  (rise_p[i]),
            .fall  (fall_p[i])
        );
    end

    assign clr_rise = (wr && addr == PORTI_RISE) ? wdata : '0;
    assign clr_fall = (wr && addr == PORTI_FALL) ? wdata : '0;

    // A new edge overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_f <= '0;
            fall_f <= '0;
        end else begin
            rise_f <= (rise_f & ~clr_rise) | rise_p;
            fall_f <= (fall_f & ~clr_fall) | fall_p;
        end
    end

`ifdef PORTI_IRQ_EN
    logic [WIDTH-1:0] ie;

    always_ff @(posedge clk) begin
        if (reset) begin
            ie  <= '0;
            irq <= 1'b0;
        end else begin
            if (wr && addr == PORTI_IE) ie <= wdata;
            irq <= |((rise_f | fall_f) & ie);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (addr)
            PORTI_DATA: rd_val = level;
            PORTI_RISE: rd_val = rise_f;
            PORTI_FALL: rd_val = fall_f;
            PORTI_RAW:  rd_val = raw;
`ifdef PORTI_IRQ_EN
            PORTI_IE:   rd_val = ie;
`endif
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)          rdata <= '0;
        else if (cs && !wen) rdata <= rd_val;
    end

endmodule

// File: doc/porti_ctrl.md
Name: porti_ctrl

Overview:
- Memory-mapped input-port peripheral inside comp. It is the receiving end of the PORTI button/switch lines that the bench and board drive.
- Synchronises and debounces each PORTI bit, then latches sticky rising- and falling-edge flags.
- The CPU reads state and flags over the simple peripheral bus and clears flags with write-1-to-clear.
- Optionally raises an interrupt request.

Parameters:
- WIDTH, 32: number of PORTI bits; also the bus data width.
- DIV, 10: clk cycles per debounce sample tick (>=1).
- STABLE, 3: consecutive equal samples needed to accept a new level (1..7).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  peripheral select.
- wen  input  1  write enable, qualified by cs.
- addr  input  3  register index.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  read data, registered.
- porti  input  WIDTH  raw asynchronous button inputs.
- irq  output  1  level interrupt request (feature-dependent).

Behaviour:
- Register map:
  - addr 0 DATA (RO): debounced levels.
  - addr 1 RISE (R/W1C): sticky rising-edge flags.
  - addr 2 FALL (R/W1C): sticky falling-edge flags.
  - addr 3 RAW (RO): synchronised, undebounced input.
  - addr 4 IE (R/W, feature only): interrupt enable mask.
  - addr 5..7 read 0; writes to them are ignored.
- Synchroniser: two flops per bit. RAW is the second stage.
- Tick counter: counts 0..DIV-1 and pulses tick for one cycle at DIV-1, then wraps to 0. Reset sets it to 0. DIV=1 gives a tick every cycle.
- Per-bit debounce:
  - Each bit has a 3-bit counter cnt.
  - On tick, if RAW != DATA: cnt increments. When cnt+1 == STABLE, DATA flips and cnt clears.
  - On tick, if RAW == DATA: cnt clears.
  - Without a tick, cnt holds.
  - Worst-case acceptance latency: 2 + STABLE*DIV clk cycles after a clean input change.
- Edge flags:
  - When DATA flips 0->1, the RISE bit sets in the same cycle DATA updates. 1->0 sets the FALL bit likewise.
  - Flags stay set until cleared by a write with cs & wen, where the wdata bit = 1.
  - If a flag sets and is W1C-cleared in the same cycle, the set wins and the flag stays 1.
- Read: when cs & !wen, rdata takes the addressed register one cycle later. Otherwise rdata holds its last value. Reads have no side effects.
- Reset (synchronous):
  - DATA, RISE, FALL, IE, cnt, synchronisers, tick counter and rdata all go to 0; irq goes to 0.
  - A button held high through reset is accepted after the debounce latency and raises RISE. This is intended.
- Reset asserted mid-debounce discards the partial count. No edge is flagged for the aborted transition.
- Glitch shorter than one tick interval: at most one mismatching sample, so cnt clears and DATA does not change.

Optional Feature:
- Macro: PORTI_IRQ_EN.
- Defined:
  - IE register exists at addr 4.
  - irq is registered: irq = |((RISE|FALL) & IE), one cycle after the flag or IE change.
  - irq drops one cycle after the clearing write.
- Undefined:
  - irq is tied to 0.
  - addr 4 reads 0 and writes are ignored.
  - No IE flops are synthesised.

Decomposition:
- Shared package porti_pkg holds:
  - register index constants: PORTI_DATA=0, PORTI_RISE=1, PORTI_FALL=2, PORTI_RAW=3, PORTI_IE=4;
  - the counter-width constant (3).
- One natural sub-module, porti_debounce_bit: synchroniser, cnt, DATA bit and edge pulses for a single bit. It is instantiated WIDTH times in a generate loop. The tick counter is shared in the top.

Test Plan:
- Reset then idle (DIV=10, STABLE=3, porti=0) -> DATA=0, RISE=0, FALL=0, irq=0, rdata=0 across 200 cycles.
- Clean press: porti=32'd4 held -> DATA bit2=1 within 2+30 cycles, RISE=32'd4, FALL=0. Release porti=0 -> DATA=0, FALL=32'd4, RISE still 32'd4.
- Glitch: porti bit0 high for 5 cycles placed between ticks -> DATA, RISE and FALL stay 0.
- W1C: with RISE=32'd4, write addr1 wdata=32'd4 -> next read RISE=0. Write addr1 in the exact cycle a new edge on bit2 lands -> RISE bit2 stays 1.
- IRQ (PORTI_IRQ_EN): IE=32'd4, press bit2 -> irq=1 one cycle after RISE sets. Clear RISE -> irq=0 next cycle. With IE=0, a press gives irq=0. Macro undefined: irq=0 always and addr4 reads 0.
- Reset mid-debounce: assert reset after 2 of 3 matching ticks -> DATA=0 and RISE=0. After release with porti still 4, DATA=1 only after a full 3-tick window.
